// File: rtl/btn_onehot_selector.sv
// Four-button front end: synchronize, debounce and edge-detect each raw button,
// then latch a one-hot selection from the lowest-index new press.
module btn_onehot_selector #(
  parameter int N_BTN           = 4,
  parameter int DEBOUNCE_CYCLES = 1000000,
  parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_BTN-1:0] btn_in,
  output logic [N_BTN-1:0] btn_clean,
  output logic [N_BTN-1:0] btn_pulse,
  output logic [N_BTN-1:0] sel,
  output logic             sel_valid
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [N_BTN-1:0] SEL_RST = N_BTN'(1);

  logic [N_BTN-1:0] s1;
  logic [N_BTN-1:0] s2;
  logic [CNT_W-1:0] cnt [N_BTN];
  logic [N_BTN-1:0] accept;
  logic [N_BTN-1:0] cand;

  // accept[i]: s2 has now differed from btn_clean on DEBOUNCE_CYCLES edges
  always_comb begin
    accept = '0;
    for (int i = 0; i < N_BTN; i++) begin
      accept[i] = (s2[i] != btn_clean[i]) && (cnt[i] == CNT_MAX);
    end
  end

  // Isolate the lowest set bit so simultaneous presses resolve to the lowest index
  always_comb begin
    cand = btn_pulse & (~btn_pulse + SEL_RST);
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      s1 <= '0;
      s2 <= '0;
    end else begin
      s1 <= btn_in;
      s2 <= s1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      btn_clean <= '0;
      btn_pulse <= '0;
      for (int i = 0; i < N_BTN; i++) begin
        cnt[i] <= '0;
      end
    end else begin
      btn_pulse <= accept & s2;
      for (int i = 0; i < N_BTN; i++) begin
        if (s2[i] == btn_clean[i]) begin
          cnt[i] <= '0;
        end else if (accept[i]) begin
          btn_clean[i] <= s2[i];
          cnt[i]       <= '0;
        end else begin
          cnt[i] <= cnt[i] + CNT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sel       <= SEL_RST;
      sel_valid <= 1'b0;
    end else if ((btn_pulse != '0) && (cand != sel)) begin
      sel       <= cand;
      sel_valid <= 1'b1;
    end else begin
      sel_valid <= 1'b0;
    end
  end

endmodule
